// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event arbiter: event/state encodings and
// timing conversion used to size the prescaler and per-button counters.
package button_event_pkg;

    typedef enum logic [1:0] {
        EvtPress   = 2'd0,
        EvtRelease = 2'd1,
        EvtLong    = 2'd2,
        EvtRepeat  = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StHeld    = 2'd2
    } btn_state_e;

    localparam int unsigned EVT_BTN_W = 3;

    function automatic int unsigned ms_to_ticks(input int unsigned freq_hz,
                                                input int unsigned ms);
        return (freq_hz / 1000) * ms;
    endfunction

    // Bits needed to hold values 0..max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press tracker: level register, IDLE/PRESSED/HELD FSM with ms counter,
// and a single pending event slot with sticky overflow.
module btn_press_fsm
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      i_level,
    input  logic      i_ms_tick,
    input  logic      i_ack,
    output logic      o_pend,
    output evt_type_e o_type,
    output logic      o_overflow
);

    localparam int unsigned CNT_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    logic             r_level;
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    evt_type_e        r_type;
    logic             r_overflow;

    btn_state_e       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_raise;
    evt_type_e        w_raise_type;

    // Edges are inferred from the registered level against the FSM state, so a single
    // level register suffices and a level held through reset reads as a fresh press.
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_raise      = 1'b0;
        w_raise_type = EvtPress;
        case (r_state)
            StIdle: begin
                if (r_level) begin
                    w_state_d = StPressed;
                    w_cnt_d   = '0;
                    w_raise   = 1'b1;
                end
            end
            StPressed: begin
                if (!r_level) begin
                    w_state_d    = StIdle;
                    w_cnt_d      = '0;
                    w_raise      = 1'b1;
                    w_raise_type = EvtRelease;
                end else if (i_ms_tick) begin
                    if (r_cnt == LONG_LAST) begin
                        w_state_d    = StHeld;
                        w_cnt_d      = '0;
                        w_raise      = 1'b1;
                        w_raise_type = EvtLong;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
            end
            StHeld: begin
                if (!r_level) begin
                    w_state_d    = StIdle;
                    w_cnt_d      = '0;
                    w_raise      = 1'b1;
                    w_raise_type = EvtRelease;
                end else if (i_ms_tick) begin
                    if (r_cnt == REPEAT_LAST) begin
                        w_cnt_d      = '0;
                        w_raise      = 1'b1;
                        w_raise_type = EvtRepeat;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_level    <= 1'b0;
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_type     <= EvtPress;
            r_overflow <= 1'b0;
        end else begin
            r_level <= i_level;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            // A slot being accepted this cycle is free for the new event.
            if (w_raise) begin
                if (!r_pend || i_ack) begin
                    r_pend <= 1'b1;
                    r_type <= w_raise_type;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (i_ack) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend     = r_pend;
    assign o_type     = r_type;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: shared ms prescaler, one press FSM per button, and a
// round-robin arbiter driving a registered valid/ready event output.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned CLOCK_FREQ    = 24000000,
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NUM_BTN-1:0]   btn_level,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [EVT_BTN_W-1:0] evt_btn,
    output logic [1:0]           evt_type,
    output logic [NUM_BTN-1:0]   overflow
);

    localparam int unsigned PRESC_DIV =
        (ms_to_ticks(CLOCK_FREQ, 1) > 0) ? ms_to_ticks(CLOCK_FREQ, 1) : 1;
    localparam int unsigned PRESC_W = cnt_width(PRESC_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0]   r_presc;
    logic                 w_ms_tick;

    logic [NUM_BTN-1:0]   w_pend;
    evt_type_e            w_type [NUM_BTN];
    logic [NUM_BTN-1:0]   w_ack;
    logic [NUM_BTN-1:0]   w_elig;

    logic                 w_hi_found;
    logic                 w_lo_found;
    logic [EVT_BTN_W-1:0] w_hi_idx;
    logic [EVT_BTN_W-1:0] w_lo_idx;
    evt_type_e            w_hi_type;
    evt_type_e            w_lo_type;
    logic                 w_win_valid;
    logic [EVT_BTN_W-1:0] w_win_idx;
    evt_type_e            w_win_type;

    logic                 r_evt_valid;
    logic [EVT_BTN_W-1:0] r_evt_btn;
    evt_type_e            r_evt_type;
    logic [EVT_BTN_W-1:0] r_last;

    assign w_ms_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_ms_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_press_fsm #(
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .REPEAT_MS     (REPEAT_MS)
        ) u_btn_press_fsm (
            .clk        (clk),
            .n_rst      (n_rst),
            .i_level    (btn_level[g]),
            .i_ms_tick  (w_ms_tick),
            .i_ack      (w_ack[g]),
            .o_pend     (w_pend[g]),
            .o_type     (w_type[g]),
            .o_overflow (overflow[g])
        );
    end

    // The presented slot stays pending until accepted, so it is excluded from the next pick.
    always_comb begin
        w_ack  = '0;
        w_elig = w_pend;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (r_evt_valid && (r_evt_btn == EVT_BTN_W'(i))) begin
                w_ack[i]  = evt_ready;
                w_elig[i] = 1'b0;
            end
        end
    end

    // Round-robin: first eligible index above r_last wins, else first at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_type  = EvtPress;
        w_lo_type  = EvtPress;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_elig[i]) begin
                if (EVT_BTN_W'(i) > r_last) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = EVT_BTN_W'(i);
                        w_hi_type  = w_type[i];
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = EVT_BTN_W'(i);
                    w_lo_type  = w_type[i];
                end
            end
        end
        w_win_valid = w_hi_found | w_lo_found;
        w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        w_win_type  = w_hi_found ? w_hi_type : w_lo_type;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_evt_valid <= 1'b0;
            r_evt_btn   <= '0;
            r_evt_type  <= EvtPress;
            r_last      <= EVT_BTN_W'(NUM_BTN - 1);
        end else if (!r_evt_valid || evt_ready) begin
            r_evt_valid <= w_win_valid;
            if (w_win_valid) begin
                r_evt_btn  <= w_win_idx;
                r_evt_type <= w_win_type;
                r_last     <= w_win_idx;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_btn   = r_evt_btn;
    assign evt_type  = r_evt_type;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter with a 10-cycle millisecond.
module tb_button_event_arbiter;
    import button_event_pkg::*;

    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [NB-1:0] btn_level = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [2:0]    evt_btn;
    logic [1:0]    evt_type;
    logic [NB-1:0] overflow;

    typedef struct packed {
        logic [2:0] btn;
        logic [1:0] typ;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .NUM_BTN       (NB),
        .CLOCK_FREQ    (10000),
        .LONG_PRESS_MS (5),
        .REPEAT_MS     (2)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_type  (evt_type),
        .overflow  (overflow)
    );

    // Scoreboard: every accepted handshake must match the oldest expected event.
    exp_t m_e;
    always @(negedge clk) begin
        if (n_rst === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL sb_unexpected: got btn=%0d type=%0d, required no event",
                         evt_btn, evt_type);
            end else begin
                m_e = exp_q.pop_front();
                if (evt_btn !== m_e.btn || evt_type !== m_e.typ) begin
                    n_fails++;
                    $display("FAIL sb_event: got btn=%0d type=%0d, required btn=%0d type=%0d",
                             evt_btn, evt_type, m_e.btn, m_e.typ);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input evt_type_e t);
        exp_t e;
        e.btn = 3'(b);
        e.typ = t;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        n_rst = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            cyc();
            if (evt_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        btn_level = '0;
        evt_ready = 1'b0;
        cyc();
        cyc();
        n_checks++; if (evt_valid !== 1'b0) begin n_fails++;
            $display("FAIL reset_valid: got %b, required 0", evt_valid); end
        n_checks++; if (evt_btn !== 3'd0) begin n_fails++;
            $display("FAIL reset_btn: got %0d, required 0", evt_btn); end
        n_checks++; if (evt_type !== EvtPress) begin n_fails++;
            $display("FAIL reset_type: got %0d, required 0", evt_type); end
        n_checks++; if (overflow !== 4'b0000) begin n_fails++;
            $display("FAIL reset_overflow: got %b, required 0000", overflow); end
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) cyc();
        n_checks++; if (evt_valid !== 1'b0) begin n_fails++;
            $display("FAIL idle_valid: got %b, required 0", evt_valid); end
    endtask

    task automatic test_short_press();
        int lat;
        int extra;
        do_reset();
        evt_ready = 1'b1;
        push(0, EvtPress);
        btn_level = 4'b0001;
        wait_valid(10, lat);
        n_checks++; if (lat != 3 || evt_btn !== 3'd0 || evt_type !== EvtPress) begin
            n_fails++;
            $display("FAIL short_press: got lat=%0d btn=%0d type=%0d, required 3/0/0",
                     lat, evt_btn, evt_type); end
        extra = 0;
        for (int c = 0; c < 17; c++) begin cyc(); if (evt_valid === 1'b1) extra++; end
        n_checks++; if (extra != 0) begin n_fails++;
            $display("FAIL short_hold_quiet: got %0d events, required 0", extra); end
        push(0, EvtRelease);
        btn_level = 4'b0000;
        wait_valid(10, lat);
        n_checks++; if (lat != 3 || evt_btn !== 3'd0 || evt_type !== EvtRelease) begin
            n_fails++;
            $display("FAIL short_release: got lat=%0d btn=%0d type=%0d, required 3/0/1",
                     lat, evt_btn, evt_type); end
        extra = 0;
        for (int c = 0; c < 60; c++) begin cyc(); if (evt_valid === 1'b1) extra++; end
        n_checks++; if (extra != 0 || overflow !== 4'b0000) begin n_fails++;
            $display("FAIL short_after: got events=%0d ovf=%b, required 0/0000",
                     extra, overflow); end
        n_checks++; if (exp_q.size() != 0) begin n_fails++;
            $display("FAIL short_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_long_repeat();
        int t[8];
        int n;
        do_reset();
        evt_ready = 1'b1;
        push(1, EvtPress);
        push(1, EvtLong);
        push(1, EvtRepeat);
        push(1, EvtRepeat);
        push(1, EvtRelease);
        for (int i = 0; i < 8; i++) t[i] = 0;
        n = 0;
        btn_level = 4'b0010;
        for (int c = 1; c <= 110; c++) begin
            if (c == 101) btn_level = 4'b0000;
            cyc();
            if (evt_valid === 1'b1 && n < 8) begin t[n] = c; n++; end
        end
        n_checks++; if (n != 5) begin n_fails++;
            $display("FAIL long_count: got %0d events, required 5", n); end
        n_checks++; if (t[0] != 3) begin n_fails++;
            $display("FAIL long_press_lat: got %0d, required 3", t[0]); end
        n_checks++; if ((t[1] - t[0]) < 41 || (t[1] - t[0]) > 50) begin n_fails++;
            $display("FAIL long_delay: got %0d, required 41..50", t[1] - t[0]); end
        n_checks++; if ((t[2] - t[1]) != 20 || (t[3] - t[2]) != 20) begin n_fails++;
            $display("FAIL repeat_gap: got %0d/%0d, required 20/20",
                     t[2] - t[1], t[3] - t[2]); end
        n_checks++; if (t[4] != 103) begin n_fails++;
            $display("FAIL long_release_time: got %0d, required 103", t[4]); end
        n_checks++; if (exp_q.size() != 0 || overflow !== 4'b0000) begin n_fails++;
            $display("FAIL long_drain: got left=%0d ovf=%b, required 0/0000",
                     exp_q.size(), overflow); end
    endtask

    task automatic test_simultaneous();
        int lat;
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(i, EvtPress);
        btn_level = 4'b1111;
        wait_valid(10, lat);
        n_checks++; if (lat != 3) begin n_fails++;
            $display("FAIL burst_lat: got %0d, required 3", lat); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 3'(i)) begin n_fails++;
                $display("FAIL burst_press_order: slot %0d got valid=%b btn=%0d, required 1/%0d",
                         i, evt_valid, evt_btn, i); end
            cyc();
        end
        n_checks++; if (evt_valid !== 1'b0) begin n_fails++;
            $display("FAIL burst_gap: got %b, required 0", evt_valid); end
        for (int c = 0; c < 8; c++) cyc();
        for (int i = 0; i < 4; i++) push(i, EvtRelease);
        btn_level = 4'b0000;
        wait_valid(10, lat);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 3'(i) || evt_type !== EvtRelease)
            begin n_fails++;
                $display("FAIL burst_release_order: slot %0d got valid=%b btn=%0d type=%0d, required 1/%0d/1",
                         i, evt_valid, evt_btn, evt_type, i); end
            cyc();
        end
        n_checks++; if (exp_q.size() != 0 || overflow !== 4'b0000) begin n_fails++;
            $display("FAIL burst_drain: got left=%0d ovf=%b, required 0/0000",
                     exp_q.size(), overflow); end
    endtask

    task automatic test_backpressure();
        int bad;
        int extra;
        do_reset();
        evt_ready = 1'b0;
        push(2, EvtPress);
        btn_level = 4'b0100;
        bad = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c == 21)  btn_level = 4'b0000;
            if (c == 41)  btn_level = 4'b0100;
            if (c == 181) btn_level = 4'b0000;
            cyc();
            if (c >= 3) begin
                if (!(evt_valid === 1'b1 && evt_btn === 3'd2 && evt_type === EvtPress)) bad++;
            end else if (evt_valid !== 1'b0) begin
                bad++;
            end
        end
        n_checks++; if (bad != 0) begin n_fails++;
            $display("FAIL stall_stable: got %0d bad cycles, required 0", bad); end
        n_checks++; if (overflow !== 4'b0100) begin n_fails++;
            $display("FAIL stall_overflow: got %b, required 0100", overflow); end
        evt_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 10; c++) begin cyc(); if (evt_valid === 1'b1) extra++; end
        n_checks++; if (extra != 0 || exp_q.size() != 0) begin n_fails++;
            $display("FAIL stall_drain: got extra=%0d left=%0d, required 0/0",
                     extra, exp_q.size()); end
        n_checks++; if (overflow !== 4'b0100) begin n_fails++;
            $display("FAIL stall_sticky: got %b, required 0100", overflow); end
    endtask

    task automatic test_accept_and_raise();
        do_reset();
        evt_ready = 1'b0;
        push(0, EvtPress);
        push(0, EvtRelease);
        btn_level = 4'b0001;
        for (int c = 0; c < 5; c++) cyc();
        n_checks++; if (evt_valid !== 1'b1 || evt_type !== EvtPress) begin n_fails++;
            $display("FAIL same_cycle_pre: got valid=%b type=%0d, required 1/0",
                     evt_valid, evt_type); end
        btn_level = 4'b0000;
        cyc();
        evt_ready = 1'b1;
        cyc();
        cyc();
        n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 3'd0 || evt_type !== EvtRelease) begin
            n_fails++;
            $display("FAIL same_cycle_release: got valid=%b btn=%0d type=%0d, required 1/0/1",
                     evt_valid, evt_btn, evt_type); end
        n_checks++; if (overflow !== 4'b0000) begin n_fails++;
            $display("FAIL same_cycle_overflow: got %b, required 0000", overflow); end
        for (int c = 0; c < 5; c++) cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fails++;
            $display("FAIL same_cycle_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        evt_ready = 1'b0;
        push(3, EvtPress);
        btn_level = 4'b1000;
        for (int c = 0; c < 60; c++) cyc();
        n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 3'd3 || overflow !== 4'b1000) begin
            n_fails++;
            $display("FAIL held_pre_reset: got valid=%b btn=%0d ovf=%b, required 1/3/1000",
                     evt_valid, evt_btn, overflow); end
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if (evt_valid !== 1'b0 || evt_btn !== 3'd0) begin n_fails++;
            $display("FAIL async_reset_out: got valid=%b btn=%0d, required 0/0",
                     evt_valid, evt_btn); end
        n_checks++; if (evt_type !== EvtPress || overflow !== 4'b0000) begin n_fails++;
            $display("FAIL async_reset_state: got type=%0d ovf=%b, required 0/0000",
                     evt_type, overflow); end
        cyc();
        n_rst = 1'b1;
        evt_ready = 1'b1;
        push(3, EvtPress);
        wait_valid(10, lat);
        n_checks++; if (lat != 3 || evt_btn !== 3'd3 || evt_type !== EvtPress) begin n_fails++;
            $display("FAIL held_through_reset: got lat=%0d btn=%0d type=%0d, required 3/3/0",
                     lat, evt_btn, evt_type); end
        push(3, EvtRelease);
        btn_level = 4'b0000;
        wait_valid(10, lat);
        for (int c = 0; c < 5; c++) cyc();
        n_checks++; if (exp_q.size() != 0 || overflow !== 4'b0000) begin n_fails++;
            $display("FAIL reset_mid_drain: got left=%0d ovf=%b, required 0/0000",
                     exp_q.size(), overflow); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_simultaneous();
        test_backpressure();
        test_accept_and_raise();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
